ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single program/data RAM (one read port, one write port, synchronous 1-cycle read) between two requesters.
  - Port 0: CPU instruction/data fetch.
  - Port 1: program loader / debug reader.
- Sits between the cpu/loader and the ram instance, and drives ram we, r_addr, w_addr and w_data.
- Provides one access per cycle, with fixed-priority or round-robin arbitration and per-port read-return tagging.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- CNT_W, 16, width of the optional grant/stall counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 access request (CPU).
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant; access performed this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (loader/debug).
- ram_we  out  1  to ram we.
- ram_r_addr  out  ADDR_W  to ram r_addr.
- ram_w_addr  out  ADDR_W  to ram w_addr.
- ram_w_data  out  DATA_W  to ram w_data.
- ram_r_data  in  DATA_W  from ram r_data (valid 1 cycle after r_addr is sampled).
- busy  out  1  a read return is pending next cycle.

Behaviour:
- Grant logic:
  - gnt0/gnt1 are combinational from req0/req1 and the registered pointer last_gnt.
  - At most one grant per cycle; gnt0 & gnt1 is never 1.
- Arbitration:
  - One requester active: it is granted the same cycle.
  - Both active, RR_EN=1: the port not equal to last_gnt wins.
  - Both active, RR_EN=0: port 0 always wins.
  - last_gnt updates on the clock edge after any grant. It holds when there is no grant.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high at a clock edge.
  - Deasserting req before grant is legal; the request is simply dropped.
  - Back-to-back requests on consecutive cycles are allowed. A port may be granted every cycle when it is the only requester.
- RAM drive on the granted cycle:
  - ram_r_addr = granted addr.
  - Write: ram_we = 1, ram_w_addr = addr, ram_w_data = wdata.
  - No grant: ram_we = 0, addresses = 0, ram_w_data = 0.
- Read latency:
  - A read granted in cycle N returns in cycle N+1: rvalidX = 1 for exactly one cycle, rdataX = ram_r_data.
  - Writes produce no rvalid.
  - The return tag is registered: rd_pend and rd_id.
  - rdata of the non-returning port is 0.
- Writes and reads are fully pipelined:
  - A read return in N+1 coexists with a new grant in N+1.
  - A read-after-write to the same address in consecutive cycles returns the new data (the ram writes on the edge ending the grant cycle).
- busy = rd_pend.
- Reset (synchronous, active-high):
  - last_gnt = 1, so port 0 wins the first tie.
  - rd_pend = 0, rd_id = 0, rvalid0/1 = 0, rdata0/1 = 0.
  - gnt0/gnt1 = 0 and ram_we = 0 while reset is high, regardless of req.
- Reset mid-operation: a read granted in the cycle before reset is asserted produces no rvalid; the pending return is discarded.
- Address/data widths pass through unmodified. There is no wrap or arithmetic on addresses.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0, gnt_cnt1, stall_cnt0 and stall_cnt1, each CNT_W wide.
  - gnt_cntX increments on each gntX.
  - stall_cntX increments on each cycle with reqX=1 and gntX=0.
  - All counters saturate at all-ones (no wrap) and clear to 0 on reset.
- Not defined: no counter ports and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then req0=1 read at addr0=0x00 with ram[0]=0x12 -> gnt0=1 the same cycle; next cycle rvalid0=1, rdata0=0x12, rvalid1=0.
- req1 write addr1=0x05, wdata1=0xA5, then req1 read 0x05 the following cycle -> ram_we=1 with w_addr=0x05; read returns rdata1=0xA5 one cycle after its grant.
- RR_EN=1, req0 and req1 held high for 4 cycles after reset -> grants alternate 0,1,0,1; rvalid0/rvalid1 alternate, each tagged correctly.
- RR_EN=0, same stimulus -> gnt0 on all 4 cycles, gnt1=0; with ARB_STATS_EN, stall_cnt1=4 and gnt_cnt0=4.
- Read granted to port 1, reset asserted the next cycle for 1 cycle -> rvalid1 stays 0, busy=0, no grants while reset is high.
- With ARB_STATS_EN, CNT_W=4, req0 alone held for 20 cycles -> gnt_cnt0 saturates at 0xF and does not wrap.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-read/single-write synchronous RAM.
// Optional grant/stall counters are enabled by defining ARB_STATS_EN.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter bit          RR_EN  = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1,
    output logic [CNT_W-1:0]  stall_cnt0,
    output logic [CNT_W-1:0]  stall_cnt1
`endif
);

    logic last_gnt;
    logic rd_pend;
    logic rd_id;
    logic rd_grant;
    logic live_pend;

    // Grant decision; last_gnt = 1 means port 1 was granted most recently.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if (RR_EN) begin
                    gnt0 = last_gnt;
                    gnt1 = ~last_gnt;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // RAM drive for the granted access; idle cycles present all zeros.
    always_comb begin
        ram_we     = 1'b0;
        ram_r_addr = '0;
        ram_w_addr = '0;
        ram_w_data = '0;
        if (gnt0) begin
            ram_r_addr = addr0;
            if (we0) begin
                ram_we     = 1'b1;
                ram_w_addr = addr0;
                ram_w_data = wdata0;
            end
        end else if (gnt1) begin
            ram_r_addr = addr1;
            if (we1) begin
                ram_we     = 1'b1;
                ram_w_addr = addr1;
                ram_w_data = wdata1;
            end
        end
    end

    assign rd_grant = (gnt0 & ~we0) | (gnt1 & ~we1);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            if (gnt0) begin
                last_gnt <= 1'b0;
            end else if (gnt1) begin
                last_gnt <= 1'b1;
            end
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_id <= gnt1;
            end
        end
    end

    // A return already in flight when reset rises is suppressed.
    assign live_pend = rd_pend & ~reset;
    assign busy      = live_pend;
    assign rvalid0   = live_pend & ~rd_id;
    assign rvalid1   = live_pend & rd_id;
    assign rdata0    = rvalid0 ? ram_r_data : '0;
    assign rdata1    = rvalid1 ? ram_r_data : '0;

`ifdef ARB_STATS_EN
    // Saturating grant and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (gnt0 && (gnt_cnt0 != '1)) begin
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            end
            if (gnt1 && (gnt_cnt1 != '1)) begin
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            end
            if (req0 && !gnt0 && (stall_cnt0 != '1)) begin
                stall_cnt0 <= stall_cnt0 + CNT_W'(1);
            end
            if (req1 && !gnt1 && (stall_cnt1 != '1)) begin
                stall_cnt1 <= stall_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
